// File: rtl/servile_wb_cmd_master.sv
// Host byte-stream command decoder that issues single 32-bit Wishbone cycles on
// the shared-SRAM port and answers with read-data bytes or an 8'hA5 write ack.
module servile_wb_cmd_master #(
  parameter  int depth = 256,
  localparam int aw    = $clog2(depth)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  output logic          o_rx_ready,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_valid,
  input  logic          i_tx_ready,
  output logic [aw-3:0] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_stb,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack,
  output logic          o_busy
);

  // state     | meaning
  // CMD       | idle, waiting for command byte
  // ADR0/ADR1 | address low/high byte
  // DAT0..3   | write data bytes, little-endian
  // BUS       | Wishbone cycle in flight, waiting for ack
  // RSP0..3   | presenting read-data bytes
  // WACK      | presenting write acknowledge 8'hA5
  typedef enum logic [3:0] {
    CMD, ADR0, ADR1, DAT0, DAT1, DAT2, DAT3, BUS,
    RSP0, RSP1, RSP2, RSP3, WACK
  } state_t;

  localparam int AWW = aw - 2;

  state_t      state, state_nxt;
  logic [5:0]  adr_lo;
  logic [31:0] rdata;
  logic        rx_xfer;
  logic        tx_xfer;

  assign rx_xfer = i_rx_valid & o_rx_ready;
  assign tx_xfer = o_tx_valid & i_tx_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= CMD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    o_rx_ready = 1'b0;
    o_tx_valid = 1'b0;
    o_tx_data  = 8'h00;
    o_wb_stb   = 1'b0;
    o_busy     = 1'b1;
    case (state)
      CMD: begin
        o_busy     = 1'b0;
        o_rx_ready = 1'b1;
        if (rx_xfer) state_nxt = ADR0;
      end
      ADR0: begin
        o_rx_ready = 1'b1;
        if (rx_xfer) state_nxt = ADR1;
      end
      ADR1: begin
        o_rx_ready = 1'b1;
        if (rx_xfer) state_nxt = o_wb_we ? DAT0 : BUS;
      end
      DAT0: begin
        o_rx_ready = 1'b1;
        if (rx_xfer) state_nxt = DAT1;
      end
      DAT1: begin
        o_rx_ready = 1'b1;
        if (rx_xfer) state_nxt = DAT2;
      end
      DAT2: begin
        o_rx_ready = 1'b1;
        if (rx_xfer) state_nxt = DAT3;
      end
      DAT3: begin
        o_rx_ready = 1'b1;
        if (rx_xfer) state_nxt = BUS;
      end
      BUS: begin
        o_wb_stb = 1'b1;
        if (i_wb_ack) state_nxt = o_wb_we ? WACK : RSP0;
      end
      RSP0: begin
        o_tx_valid = 1'b1;
        o_tx_data  = rdata[7:0];
        if (tx_xfer) state_nxt = RSP1;
      end
      RSP1: begin
        o_tx_valid = 1'b1;
        o_tx_data  = rdata[15:8];
        if (tx_xfer) state_nxt = RSP2;
      end
      RSP2: begin
        o_tx_valid = 1'b1;
        o_tx_data  = rdata[23:16];
        if (tx_xfer) state_nxt = RSP3;
      end
      RSP3: begin
        o_tx_valid = 1'b1;
        o_tx_data  = rdata[31:24];
        if (tx_xfer) state_nxt = CMD;
      end
      WACK: begin
        o_tx_valid = 1'b1;
        o_tx_data  = 8'hA5;
        if (tx_xfer) state_nxt = CMD;
      end
      default: state_nxt = CMD;
    endcase
  end

  // Bus fields only change in rx states, so they are frozen while stb is high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      adr_lo   <= 6'd0;
      rdata    <= 32'd0;
      o_wb_adr <= '0;
      o_wb_dat <= 32'd0;
      o_wb_sel <= 4'h0;
      o_wb_we  <= 1'b0;
    end else begin
      if (rx_xfer) begin
        case (state)
          CMD: begin
            o_wb_we  <= i_rx_data[0];
            o_wb_sel <= i_rx_data[0] ? i_rx_data[7:4] : 4'hF;
          end
          ADR0:    adr_lo          <= i_rx_data[7:2];
          ADR1:    o_wb_adr        <= AWW'({i_rx_data, adr_lo});
          DAT0:    o_wb_dat[7:0]   <= i_rx_data;
          DAT1:    o_wb_dat[15:8]  <= i_rx_data;
          DAT2:    o_wb_dat[23:16] <= i_rx_data;
          DAT3:    o_wb_dat[31:24] <= i_rx_data;
          default: ;
        endcase
      end
      if (state == BUS && i_wb_ack) rdata <= i_wb_rdt;
    end
  end

endmodule

// File: tb/tb_servile_wb_cmd_master.sv
// Randomised and directed bench for servile_wb_cmd_master: frame-level reference
// model (word memory plus expected bus/tx queues) and an every-cycle compare process.
module tb_servile_wb_cmd_master;
  localparam int DEPTH = 256;
  localparam int NW    = DEPTH / 4;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic [5:0]  o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_stb;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;
  logic        o_busy;

  always #5 clk = ~clk;

  servile_wb_cmd_master #(.depth(DEPTH)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
    .o_wb_we(o_wb_we), .o_wb_stb(o_wb_stb), .i_wb_rdt(i_wb_rdt),
    .i_wb_ack(i_wb_ack), .o_busy(o_busy)
  );

  typedef struct {
    int          adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } bus_t;
  typedef struct {
    logic [7:0] b;
    logic       last;
  } tx_t;

  int n_checks = 0;
  int n_err    = 0;

  bus_t        exp_bus[$];
  tx_t         exp_tx[$];
  logic [7:0]  got_tx[$];
  logic [31:0] ref_mem[NW];
  logic [31:0] smem[NW];

  int   ack_delay  = 3;
  logic stray_req  = 1'b0;
  int   tx_mode    = 2;

  int          bus_count    = 0;
  int          stb_len      = 0;
  int          last_stb_len = 0;
  logic        in_stb       = 1'b0;
  logic        prev_stb_ack = 1'b0;
  logic        prev_last    = 1'b0;
  logic        prev_hold    = 1'b0;
  logic [7:0]  held_data    = 8'h00;
  logic [5:0]  cap_adr      = 6'h00;
  logic [31:0] cap_dat      = 32'h0;
  logic [3:0]  cap_sel      = 4'h0;
  logic        cap_we       = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    return (32'h0101_0101 * (i + 1)) ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Wishbone slave: word memory, programmable ack latency, optional stray acks
  initial begin
    int cnt;
    cnt = 0;
    i_wb_ack = 1'b0;
    i_wb_rdt = 32'h0;
    for (int i = 0; i < NW; i++) smem[i] = init_word(i);
    forever begin
      @(posedge clk); #1;
      i_wb_rdt = $urandom;
      if (i_wb_ack) begin
        i_wb_ack = 1'b0;
        cnt = 0;
      end else if (o_wb_stb) begin
        if (cnt >= ack_delay) begin
          i_wb_rdt = smem[o_wb_adr];
          if (o_wb_we)
            for (int b = 0; b < 4; b++)
              if (o_wb_sel[b]) smem[o_wb_adr][8*b +: 8] = o_wb_dat[8*b +: 8];
          i_wb_ack = 1'b1;
          cnt = 0;
        end else cnt++;
      end else begin
        cnt = 0;
        if (stray_req) begin
          i_wb_ack  = 1'b1;
          stray_req = 1'b0;
        end
      end
    end
  end

  // Response sink: 0 = random ready, 1 = stalled, 2 = always ready
  initial begin
    i_tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (tx_mode)
        0:       i_tx_ready = ($urandom_range(0, 2) != 0);
        1:       i_tx_ready = 1'b0;
        default: i_tx_ready = 1'b1;
      endcase
    end
  end

  // Compare process: every cycle against the frame-level expectations
  always @(negedge clk) begin
    if (i_rst) begin
      prev_stb_ack = 1'b0;
      prev_last    = 1'b0;
      prev_hold    = 1'b0;
      in_stb       = 1'b0;
    end else begin
      if (prev_stb_ack) begin
        chk("stb_low_after_ack", o_wb_stb, 1'b0);
        chk("tx_valid_after_ack", o_tx_valid, 1'b1);
      end
      if (prev_last) begin
        chk("rx_ready_after_rsp", o_rx_ready, 1'b1);
        chk("idle_after_rsp", o_busy, 1'b0);
      end
      if (prev_hold) begin
        chk("tx_valid_held", o_tx_valid, 1'b1);
        chk("tx_data_held", o_tx_data, held_data);
      end
      if (o_wb_stb || o_tx_valid) begin
        chk("busy_in_bus_rsp", o_busy, 1'b1);
        chk("no_rx_in_bus_rsp", o_rx_ready, 1'b0);
      end
      if (o_wb_stb) begin
        if (!in_stb) begin
          bus_count++;
          stb_len = 0;
          cap_adr = o_wb_adr; cap_dat = o_wb_dat; cap_sel = o_wb_sel; cap_we = o_wb_we;
          if (exp_bus.size() == 0) chk("unexpected_bus_cycle", 1, 0);
          else begin
            bus_t e;
            e = exp_bus.pop_front();
            chk("wb_adr", o_wb_adr, e.adr);
            chk("wb_we", o_wb_we, e.we);
            chk("wb_sel", o_wb_sel, e.sel);
            if (e.we) chk("wb_dat", o_wb_dat, e.dat);
          end
        end else begin
          chk("wb_adr_stable", o_wb_adr, cap_adr);
          chk("wb_dat_stable", o_wb_dat, cap_dat);
          chk("wb_sel_stable", o_wb_sel, cap_sel);
          chk("wb_we_stable", o_wb_we, cap_we);
        end
        stb_len++;
        in_stb = !i_wb_ack;
        if (i_wb_ack) last_stb_len = stb_len;
      end else in_stb = 1'b0;
      prev_stb_ack = o_wb_stb && i_wb_ack;

      prev_last = 1'b0;
      if (o_tx_valid && i_tx_ready) begin
        got_tx.push_back(o_tx_data);
        if (exp_tx.size() == 0) chk("unexpected_tx_byte", 1, 0);
        else begin
          tx_t t;
          t = exp_tx.pop_front();
          chk("tx_byte", o_tx_data, t.b);
          prev_last = t.last;
        end
      end
      prev_hold = o_tx_valid && !i_tx_ready;
      held_data = o_tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin @(posedge clk); #1; end
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    t = 0;
    @(negedge clk);
    while (!o_rx_ready && t < 2000) begin @(negedge clk); t++; end
    if (!o_rx_ready) chk("rx_accept_timeout", 0, 1);
    @(posedge clk); #1;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'($urandom);
  endtask

  // Reference model update happens at frame level, before the bytes go out
  task automatic send_frame(input logic [7:0] cmd, input logic [15:0] adr,
                            input logic [31:0] dat, input int gap);
    bus_t e;
    tx_t  t;
    int   wa;
    wa    = (int'(adr) % DEPTH) / 4;
    e.adr = wa;
    e.we  = cmd[0];
    e.sel = cmd[0] ? cmd[7:4] : 4'hF;
    e.dat = dat;
    exp_bus.push_back(e);
    if (cmd[0]) begin
      for (int b = 0; b < 4; b++)
        if (e.sel[b]) ref_mem[wa][8*b +: 8] = dat[8*b +: 8];
      t.b = 8'hA5; t.last = 1'b1;
      exp_tx.push_back(t);
    end else begin
      for (int b = 0; b < 4; b++) begin
        t.b = ref_mem[wa][8*b +: 8]; t.last = (b == 3);
        exp_tx.push_back(t);
      end
    end
    send_byte(cmd, gap);
    send_byte(adr[7:0], gap);
    send_byte(adr[15:8], gap);
    if (cmd[0]) for (int b = 0; b < 4; b++) send_byte(dat[8*b +: 8], gap);
    @(negedge clk);
    chk("stb_after_last_byte", o_wb_stb, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (!(exp_tx.size() == 0 && exp_bus.size() == 0 && !o_busy) && t < 5000) begin
      @(negedge clk); t++;
    end
    if (t >= 5000) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_got(input string name, input int n, input logic [31:0] word);
    chk({name, "_count"}, got_tx.size(), n);
    for (int i = 0; i < n && i < got_tx.size(); i++) chk(name, got_tx[i], word[8*i +: 8]);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
    $fatal(1);
  end

  initial begin
    int bc;
    for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
    i_rst = 1'b1; i_rx_valid = 1'b0; i_rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stb", o_wb_stb, 1'b0);
    chk("rst_we", o_wb_we, 1'b0);
    chk("rst_tx_valid", o_tx_valid, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_adr", o_wb_adr, 6'h00);
    chk("rst_dat", o_wb_dat, 32'h0);
    chk("rst_sel", o_wb_sel, 4'h0);
    chk("rst_tx_data", o_tx_data, 8'h00);
    @(posedge clk); #1;
    i_rst = 1'b0;
    @(negedge clk);
    chk("rx_ready_after_rst", o_rx_ready, 1'b1);
    @(posedge clk); #1;

    // Write then read
    got_tx.delete();
    send_frame(8'h01 | 8'hF0, 16'h0010, 32'hDEADBEEF, 0);
    wait_idle();
    chk("w1_adr", cap_adr, 6'h04);
    chk("w1_dat", cap_dat, 32'hDEADBEEF);
    chk("w1_sel", cap_sel, 4'hF);
    chk("w1_we", cap_we, 1'b1);
    chk_got("w1_ack", 1, 32'h0000_00A5);
    got_tx.delete();
    send_frame(8'h00, 16'h0010, 32'h0, 0);
    wait_idle();
    chk_got("r1_data", 4, 32'hDEADBEEF);

    // Byte mask: sel 0101 replaces bytes 0 and 2
    send_frame(8'hF1, 16'h0020, 32'h11223344, 0);
    wait_idle();
    send_frame(8'h51, 16'h0020, 32'hDDCCBBAA, 0);
    wait_idle();
    chk("mask_sel", cap_sel, 4'b0101);
    got_tx.delete();
    send_frame(8'h00, 16'h0020, 32'h0, 0);
    wait_idle();
    chk_got("mask_read", 4, 32'h11CC33AA);

    // Backpressure during RSP1
    got_tx.delete();
    send_frame(8'h00, 16'h0010, 32'h0, 0);
    begin
      int t;
      t = 0;
      @(negedge clk);
      while (!o_tx_valid && t < 100) begin @(negedge clk); t++; end
      chk("bp_tx_valid_seen", o_tx_valid, 1'b1);
      tx_mode = 1;
      @(posedge clk); #1;
      repeat (10) begin
        @(negedge clk);
        chk("bp_byte1_held", o_tx_data, 8'hBE);
        chk("bp_rx_blocked", o_rx_ready, 1'b0);
      end
      tx_mode = 2;
    end
    wait_idle();
    chk_got("bp_read", 4, 32'hDEADBEEF);

    // Slow slave
    ack_delay = 20;
    send_frame(8'hF1, 16'h0030, 32'hCAFEF00D, 0);
    wait_idle();
    chk("slow_stb_len", last_stb_len, 21);
    ack_delay = 3;

    // Reset mid-frame
    bc = bus_count;
    send_byte(8'hF1, 0);
    send_byte(8'h40, 0);
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_mid_no_bus", bus_count, bc);
    chk("rst_mid_idle", o_busy, 1'b0);
    got_tx.delete();
    send_frame(8'h00, 16'h0000, 32'h0, 0);
    wait_idle();
    chk_got("rst_mid_read", 4, init_word(0));

    // Address wrap with rx stalls
    send_frame(8'h00, 16'h1F04, 32'h0, 5);
    wait_idle();
    chk("wrap_adr", cap_adr, 6'h01);

    // Randomised frames with random gaps, latency, backpressure and stray acks
    tx_mode = 0;
    for (int n = 0; n < 80; n++) begin
      logic [7:0] cmd;
      cmd = 8'($urandom);
      ack_delay = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) stray_req = 1'b1;
      send_frame(cmd, 16'($urandom), $urandom, $urandom_range(0, 2));
    end
    wait_idle();
    chk("final_bus_queue", exp_bus.size(), 0);
    chk("final_tx_queue", exp_tx.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
